// File: rtl/mux4_data_flow.sv
// 4:1 data-flow multiplexer with a combinational output plus registered copies
// of the result and the select, and a one-cycle pulse on every select change.
module mux4_data_flow #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [1:0]       sel_q,
    output logic             sel_chg
);

    logic [WIDTH-1:0] en_a;
    logic [WIDTH-1:0] en_b;
    logic [WIDTH-1:0] en_c;
    logic [WIDTH-1:0] en_d;

    // Product terms are replicated across the word, so an X on a select bit
    // propagates into out in simulation instead of being silently resolved.
    assign en_a = {WIDTH{~s1 & ~s0}};
    assign en_b = {WIDTH{~s1 &  s0}};
    assign en_c = {WIDTH{ s1 & ~s0}};
    assign en_d = {WIDTH{ s1 &  s0}};

    assign out = (en_a & a) | (en_b & b) | (en_c & c) | (en_d & d);

    // Registered stage: result, select, and a change flag against the old select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            sel_q   <= 2'b00;
            sel_chg <= 1'b0;
        end else begin
            out_q   <= out;
            sel_q   <= {s1, s0};
            sel_chg <= ({s1, s0} != sel_q);
        end
    end

endmodule

// File: tb/tb_mux4_data_flow.sv
// Randomized self-checking bench for mux4_data_flow against an in-bench model.
module tb_mux4_data_flow;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a, b, c, d;
    logic         s0, s1;
    logic [W-1:0] out, out_q;
    logic [1:0]   sel_q;
    logic         sel_chg;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    mux4_data_flow #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .s0     (s0),
        .s1     (s1),
        .out    (out),
        .out_q  (out_q),
        .sel_q  (sel_q),
        .sel_chg(sel_chg)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pick(input logic [1:0] s,
                                          input logic [W-1:0] a_, b_, c_, d_);
        logic [W-1:0] v [4];
        v[0] = a_; v[1] = b_; v[2] = c_; v[3] = d_;
        return v[s];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers what was selected at each edge
    logic [W-1:0] m_out_q;
    logic [1:0]   m_sel_q;
    logic         m_chg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out_q = '0;
            m_sel_q = 2'b00;
            m_chg   = 1'b0;
        end else begin
            m_chg   = ({s1, s0} != m_sel_q);
            m_sel_q = {s1, s0};
            m_out_q = pick({s1, s0}, a, b, c, d);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out",     32'(out),     32'(pick({s1, s0}, a, b, c, d)));
            chk("out_q",   32'(out_q),   32'(m_out_q));
            chk("sel_q",   32'(sel_q),   32'(m_sel_q));
            chk("sel_chg", 32'(sel_chg), 32'(m_chg));
        end
    end

    task automatic drive_rand();
        a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
        s0 = 1'($urandom); s1 = 1'($urandom);
    endtask

    initial begin
        logic [W-1:0] sweep_exp [4];
        a = '0; b = '0; c = '0; d = '0; s0 = 1'b0; s1 = 1'b0;
        #12;
        chk("rst_out_q",   32'(out_q),   32'h0);
        chk("rst_sel_q",   32'(sel_q),   32'h0);
        chk("rst_sel_chg", 32'(sel_chg), 32'h0);
        a = 8'h5A;
        #1 chk("rst_out_live", 32'(out), 32'h5A);
        a = '0;

        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("zero_out_q", 32'(out_q), 32'h0);
        chk("zero_chg",   32'(sel_chg), 32'h0);

        // Select held at a while other inputs toggle faster
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #2;
            if (i % 4 == 0) a = ~a;
            if (i % 2 == 0) b = ~b;
            c = ~c;
            d = W'($urandom);
            #1 chk("track_a", 32'(out), 32'(a));
        end

        // Select sweep with a=0,b=1,c=0,d=1
        sweep_exp[0] = 8'h00; sweep_exp[1] = 8'h01; sweep_exp[2] = 8'h00; sweep_exp[3] = 8'h01;
        a = 8'h00; b = 8'h01; c = 8'h00; d = 8'h01;
        for (int s = 0; s < 4; s++) begin
            @(posedge clk); #2;
            {s1, s0} = 2'(s);
            #1 chk("sweep", 32'(out), 32'(sweep_exp[s]));
        end

        // Select 00 -> 10: one-cycle pulse
        @(posedge clk); #2; {s1, s0} = 2'b00;
        @(posedge clk); #2;
        @(posedge clk); #2; {s1, s0} = 2'b10;
        @(posedge clk); #1;
        chk("chg_sel_q", 32'(sel_q), 32'h2);
        chk("chg_pulse", 32'(sel_chg), 32'h1);
        @(posedge clk); #1;
        chk("chg_clear", 32'(sel_chg), 32'h0);

        // Simultaneous select and data change
        #1; {s1, s0} = 2'b11; d = 8'hC3; c = 8'h3C;
        #1 chk("simul", 32'(out), 32'hC3);

        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            drive_rand();
        end

        // Asynchronous reset between edges
        @(posedge clk); #2; a = 8'hFF; {s1, s0} = 2'b00;
        @(posedge clk); #1;
        chk("pre_rst_out_q", 32'(out_q), 32'hFF);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_q",   32'(out_q),   32'h0);
        chk("arst_sel_q",   32'(sel_q),   32'h0);
        chk("arst_sel_chg", 32'(sel_chg), 32'h0);
        chk("arst_out",     32'(out),     32'hFF);
        @(posedge clk); #2;
        rst_n = 1'b1;
        {s1, s0} = 2'b01; b = 8'h77;
        @(posedge clk); #1;
        chk("resume_out_q", 32'(out_q),   32'h77);
        chk("resume_chg",   32'(sel_chg), 32'h1);

        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            drive_rand();
        end

        @(posedge clk); #2;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
